// File: rtl/ifu_ctrl.sv
// ---------------------------------------------------------------------------
// ifu_ctrl - instruction-fetch controller
//
// Owns the fetch PC and issues one instruction-memory request at a time over
// a valid/ready handshake. Each fetched word and its PC are handed to decode
// through a one-entry output register. Redirects from execute are accepted in
// every state. A response that belongs to a request made before the redirect
// is waited for and then thrown away, so that at most one request is ever
// outstanding.
//
// Ports
//   clk_i             clock, rising edge
//   rst_ni            asynchronous active-low reset
//   imem_req_valid_o  fetch request valid (decoded from state + PC only)
//   imem_req_ready_i  memory accepts the request this cycle
//   imem_req_addr_o   fetch address, always the current PC
//   imem_rsp_valid_i  response for the single outstanding request
//   imem_rsp_data_i   instruction word
//   imem_rsp_err_i    access fault for this response
//   inst_valid_o      output register holds an instruction
//   inst_ready_i      decode consumes the instruction
//   inst_data_o       instruction word, 0 on a fault
//   inst_pc_o         PC of inst_data_o
//   inst_err_o        fetch fault (misaligned PC or memory error)
//   redirect_valid_i  execute redirects fetch
//   redirect_pc_i     new fetch PC
// ---------------------------------------------------------------------------
module ifu_ctrl #(
  parameter int unsigned     XLEN       = 64,
  parameter logic [XLEN-1:0] RESET_ADDR = XLEN'(64'h8000_0000)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  // instruction memory request
  output logic            imem_req_valid_o,
  input  logic            imem_req_ready_i,
  output logic [XLEN-1:0] imem_req_addr_o,
  // instruction memory response
  input  logic            imem_rsp_valid_i,
  input  logic [31:0]     imem_rsp_data_i,
  input  logic            imem_rsp_err_i,
  // decode side
  output logic            inst_valid_o,
  input  logic            inst_ready_i,
  output logic [31:0]     inst_data_o,
  output logic [XLEN-1:0] inst_pc_o,
  output logic            inst_err_o,
  // control-flow redirect from execute
  input  logic            redirect_valid_i,
  input  logic [XLEN-1:0] redirect_pc_i
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_OUT  = 3'd3,
    S_DROP = 3'd4
  } state_e;

  state_e            state_q;
  logic [XLEN-1:0]   pc_q;
  logic              inst_valid_q;
  logic [31:0]       inst_data_q;
  logic [XLEN-1:0]   inst_pc_q;
  logic              inst_err_q;

  logic              pc_aligned;
  logic              req_fire;

  assign pc_aligned = (pc_q[1:0] == 2'b00);

  // The request is a pure decode of registered state; a misaligned PC never
  // reaches the memory port.
  assign imem_req_valid_o = (state_q == S_REQ) && pc_aligned;
  assign imem_req_addr_o  = pc_q;
  assign req_fire         = imem_req_valid_o && imem_req_ready_i;

  assign inst_valid_o = inst_valid_q;
  assign inst_data_o  = inst_data_q;
  assign inst_pc_o    = inst_pc_q;
  assign inst_err_o   = inst_err_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_ADDR;
      inst_valid_q <= 1'b0;
      inst_data_q  <= 32'd0;
      inst_pc_q    <= '0;
      inst_err_q   <= 1'b0;
    end else begin
      // A redirect always wins the PC; the PC+4 update below only happens on
      // the non-redirect path, so the two never collide.
      if (redirect_valid_i) begin
        pc_q <= redirect_pc_i;
      end

      unique case (state_q)
        // Single settling cycle after reset; stray responses are ignored.
        S_IDLE: begin
          state_q <= S_REQ;
        end

        S_REQ: begin
          if (redirect_valid_i) begin
            // An accepted request still owes us a response: go discard it.
            state_q <= req_fire ? S_DROP : S_REQ;
          end else if (!pc_aligned) begin
            // Fault entry built locally without touching memory.
            inst_valid_q <= 1'b1;
            inst_err_q   <= 1'b1;
            inst_data_q  <= 32'd0;
            inst_pc_q    <= pc_q;
            state_q      <= S_OUT;
          end else if (imem_req_ready_i) begin
            state_q <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (redirect_valid_i) begin
            // A response arriving with the redirect is simply dropped here.
            state_q <= imem_rsp_valid_i ? S_REQ : S_DROP;
          end else if (imem_rsp_valid_i) begin
            inst_valid_q <= 1'b1;
            inst_err_q   <= imem_rsp_err_i;
            inst_data_q  <= imem_rsp_err_i ? 32'd0 : imem_rsp_data_i;
            inst_pc_q    <= pc_q;
            // A faulting fetch leaves the PC parked on the faulting address
            // until execute redirects us away.
            if (!imem_rsp_err_i) begin
              pc_q <= pc_q + XLEN'(4);
            end
            state_q <= S_OUT;
          end
        end

        S_OUT: begin
          // A redirect flushes the held entry; a redirect coinciding with
          // inst_ready still counts as a completed transfer to decode.
          if (redirect_valid_i || inst_ready_i) begin
            inst_valid_q <= 1'b0;
            state_q      <= S_REQ;
          end
        end

        S_DROP: begin
          if (imem_rsp_valid_i) begin
            state_q <= S_REQ;
          end
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule
